// File: rtl/motor_ramp_ctrl_pkg.sv
// ============================================================================
// Module   : motor_ctrl_pkg
// Brief    : Shared types and constants for the motor ramp sequencer.
//            MOTOR_RAMP_CTRL_ESTOP_EN adds the emergency-stop state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package motor_ctrl_pkg;

    localparam logic [1:0] SPD_OFF = 2'b00;
    localparam logic [1:0] SPD_25  = 2'b01;
    localparam logic [1:0] SPD_50  = 2'b10;
    localparam logic [1:0] SPD_75  = 2'b11;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_DEAD      = 3'd3,
        ST_ESTOP     = 3'd4
    } ramp_state_t;
`else
    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_DEAD      = 2'd3
    } ramp_state_t;
`endif

    // One speed-code step in the requested direction, clamped at the code range ends.
    function automatic logic [1:0] speed_step(input logic [1:0] cur, input logic up);
        logic [1:0] res;
        res = cur;
        if (up && (cur != SPD_75)) begin
            res = cur + 2'd1;
        end else if (!up && (cur != SPD_OFF)) begin
            res = cur - 2'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motor_ramp_ctrl_if.sv
// ============================================================================
// Module   : motor_ramp_ctrl_if
// Brief    : Speed/direction command handshake between requester and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motor_ramp_ctrl_if;
    import motor_ctrl_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_speed;
    logic       cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_speed,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_speed,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

`default_nettype wire

// File: rtl/motor_step_timer.sv
// ============================================================================
// Module   : motor_step_timer
// Brief    : Clearable up-counter with runtime terminal value and one-cycle tc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_step_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The owner clears on tc, so this stays a single-cycle pulse.
    assign tc = en && (r_count == term);
endmodule

`default_nettype wire

// File: rtl/motor_ramp_ctrl.sv
// ============================================================================
// Module   : motor_ramp_ctrl
// Brief    : Soft-start/soft-stop sequencer for the PWM motor driver control
//            word, with dead time before reversal. Optional MOTOR_RAMP_CTRL_ESTOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int DEAD_CYCLES = 8,
    parameter int CNT_W       = 24
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    input  logic               estop,
`endif
    motor_ramp_ctrl_if.slave   cmd,
    output logic [2:0]         psw,
    output logic [1:0]         cur_speed,
    output logic               busy
);
    localparam logic [CNT_W-1:0] c_step_term = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dead_term = CNT_W'(DEAD_CYCLES - 1);

    generate
        if ((STEP_CYCLES < 1) || (DEAD_CYCLES < 1) || (CNT_W < 1) || (CNT_W > 62) ||
            (longint'(STEP_CYCLES - 1) > ((longint'(1) << CNT_W) - 1)) ||
            (longint'(DEAD_CYCLES - 1) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_param
            $error("motor_ramp_ctrl: STEP_CYCLES/DEAD_CYCLES must be >=1 and fit in CNT_W bits");
        end
    endgenerate

    ramp_state_t      r_state;
    ramp_state_t      w_state_nxt;
    logic [1:0]       r_cur_speed;
    logic [1:0]       w_speed_nxt;
    logic             r_cur_dir;
    logic             w_dir_nxt;
    logic [1:0]       r_tgt_speed;
    logic [1:0]       w_tgt_speed_nxt;
    logic             r_tgt_dir;
    logic             w_tgt_dir_nxt;
    logic             r_rev;
    logic             w_rev_nxt;

    logic             w_accept;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic [CNT_W-1:0] w_term;
    logic             w_tc;
    logic [1:0]       w_spd_up;
    logic [1:0]       w_spd_dn;
    logic [1:0]       w_floor;
    logic             w_estop;

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    assign w_accept   = cmd.cmd_valid && (r_state == ST_HOLD) && !w_estop;
    assign w_timer_en = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN) ||
                        (r_state == ST_DEAD);
    assign w_term     = (r_state == ST_DEAD) ? c_dead_term : c_step_term;
    assign w_spd_up   = speed_step(r_cur_speed, 1'b1);
    assign w_spd_dn   = speed_step(r_cur_speed, 1'b0);
    // A reversal ramps down all the way to off, regardless of the new target.
    assign w_floor    = r_rev ? SPD_OFF : r_tgt_speed;

    motor_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_timer_clr),
        .en   (w_timer_en),
        .term (w_term),
        .tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_cur_speed <= SPD_OFF;
            r_cur_dir   <= DIR_FWD;
            r_tgt_speed <= SPD_OFF;
            r_tgt_dir   <= DIR_FWD;
            r_rev       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_speed <= w_speed_nxt;
            r_cur_dir   <= w_dir_nxt;
            r_tgt_speed <= w_tgt_speed_nxt;
            r_tgt_dir   <= w_tgt_dir_nxt;
            r_rev       <= w_rev_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_speed_nxt     = r_cur_speed;
        w_dir_nxt       = r_cur_dir;
        w_tgt_speed_nxt = r_tgt_speed;
        w_tgt_dir_nxt   = r_tgt_dir;
        w_rev_nxt       = r_rev;
        w_timer_clr     = 1'b0;

        case (r_state)
            ST_HOLD: begin
                if (w_accept) begin
                    w_tgt_speed_nxt = cmd.cmd_speed;
                    w_tgt_dir_nxt   = cmd.cmd_dir;
                    w_timer_clr     = 1'b1;
                    w_rev_nxt       = 1'b0;
                    if (cmd.cmd_dir != r_cur_dir) begin
                        if (r_cur_speed != SPD_OFF) begin
                            w_rev_nxt   = 1'b1;
                            w_state_nxt = ST_RAMP_DOWN;
                        end else begin
                            w_dir_nxt   = cmd.cmd_dir;
                            w_state_nxt = ST_DEAD;
                        end
                    end else if (cmd.cmd_speed > r_cur_speed) begin
                        w_state_nxt = ST_RAMP_UP;
                    end else if (cmd.cmd_speed < r_cur_speed) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end
                end
            end

            ST_RAMP_UP: begin
                if (r_cur_speed >= r_tgt_speed) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_tc) begin
                    w_speed_nxt = w_spd_up;
                    w_timer_clr = 1'b1;
                    if (w_spd_up == r_tgt_speed) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end

            ST_RAMP_DOWN: begin
                if (w_tc) begin
                    w_speed_nxt = w_spd_dn;
                    w_timer_clr = 1'b1;
                    if (w_spd_dn <= w_floor) begin
                        if (r_rev) begin
                            w_dir_nxt   = r_tgt_dir;
                            w_rev_nxt   = 1'b0;
                            w_state_nxt = ST_DEAD;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
            end

            ST_DEAD: begin
                w_speed_nxt = SPD_OFF;
                if (w_tc) begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = (r_tgt_speed != SPD_OFF) ? ST_RAMP_UP : ST_HOLD;
                end
            end

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
            ST_ESTOP: begin
                w_speed_nxt = SPD_OFF;
                if (!w_estop) begin
                    w_state_nxt = ST_HOLD;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        // Emergency stop cuts the drive immediately and discards any ramp in flight.
        if (w_estop) begin
            w_state_nxt = ST_ESTOP;
            w_speed_nxt = SPD_OFF;
            w_dir_nxt   = r_cur_dir;
            w_rev_nxt   = 1'b0;
            w_timer_clr = 1'b1;
        end
`endif
    end

    assign cmd.cmd_ready = (r_state == ST_HOLD);
    assign busy          = (r_state != ST_HOLD);
    assign cur_speed     = r_cur_speed;
    assign psw           = {r_cur_dir, r_cur_speed};
endmodule

`default_nettype wire

// File: tb/tb_motor_ramp_ctrl.sv
// ============================================================================
// Module   : tb_motor_ramp_ctrl
// Brief    : Directed self-checking bench for motor_ramp_ctrl (STEP=4, DEAD=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_ramp_ctrl;
    import motor_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] psw;
    logic [1:0] cur_speed;
    logic       busy;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_hs     = 0;
    int         hs_base;
    logic [2:0] exp_psw;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    logic       estop = 1'b0;
`endif

    motor_ramp_ctrl_if bus();

    motor_ramp_ctrl #(
        .STEP_CYCLES (4),
        .DEAD_CYCLES (8),
        .CNT_W       (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        .estop     (estop),
`endif
        .cmd       (bus.slave),
        .psw       (psw),
        .cur_speed (cur_speed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready) n_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [1:0] spd, input logic dir);
        bus.cmd_speed = spd;
        bus.cmd_dir   = dir;
        bus.cmd_valid = 1'b1;
        check("send_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_speed = 2'b00;
        bus.cmd_dir   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_psw",   32'(psw),           32'd0);
        check("rst_speed", 32'(cur_speed),     32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // Soft start to 11: steps land 4/8/12 cycles after accept
        send(2'b11, 1'b0);
        check("ss_busy0", 32'(busy), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("ss_speed", 32'(cur_speed),     32'(i / 4));
            check("ss_busy",  32'(busy),          32'(i < 12));
            check("ss_ready", 32'(bus.cmd_ready), 32'(i == 12));
        end

        // Ramp down one code, 11 -> 10
        send(2'b10, 1'b0);
        repeat (3) tick();
        check("dn_hold3", 32'(cur_speed), 32'd3);
        tick();
        check("dn_speed", 32'(cur_speed), 32'd2);
        check("dn_busy",  32'(busy),      32'd0);

        // Same-value command is consumed without any activity
        send(2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("same_busy", 32'(busy), 32'd0);
            check("same_psw",  32'(psw),  32'h2);
            tick();
        end

        // Reversal 10/fwd -> 01/rev
        send(2'b01, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i < 4)       exp_psw = 3'b010;
            else if (i < 8)  exp_psw = 3'b001;
            else if (i < 20) exp_psw = 3'b100;
            else             exp_psw = 3'b101;
            check("rev_psw",  32'(psw),  32'(exp_psw));
            check("rev_busy", 32'(busy), 32'(i < 20));
        end

        // Backpressure: second command held while the first ramps
        hs_base       = n_hs;
        bus.cmd_speed = 2'b11;
        bus.cmd_dir   = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_speed = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("bp_ready", 32'(bus.cmd_ready), 32'(i == 8));
        end
        check("bp_speed_top", 32'(cur_speed), 32'd3);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_busy", 32'(busy), 32'd1);
        repeat (11) tick();
        check("bp_speed_01", 32'(cur_speed), 32'd1);
        tick();
        check("bp_speed_off", 32'(cur_speed), 32'd0);
        check("bp_idle",      32'(busy),      32'd0);
        check("bp_accepts",   32'(n_hs - hs_base), 32'd2);

        // Reversal from standstill goes straight to dead time
        check("sd_psw_pre", 32'(psw), 32'h4);
        send(2'b00, 1'b0);
        check("sd_psw",   32'(psw),  32'h0);
        check("sd_busy0", 32'(busy), 32'd1);
        repeat (7) tick();
        check("sd_busy7", 32'(busy), 32'd1);
        tick();
        check("sd_busy8", 32'(busy), 32'd0);

        // Reset mid-ramp at speed 10
        send(2'b11, 1'b0);
        repeat (8) tick();
        check("rm_speed", 32'(cur_speed), 32'd2);
        rst = 1'b1;
        tick();
        check("rm_psw",   32'(psw),           32'd0);
        check("rm_ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b0;
        repeat (10) tick();
        check("rm_psw_after", 32'(psw),  32'd0);
        check("rm_busy",      32'(busy), 32'd0);

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        // Emergency stop at full speed
        send(2'b11, 1'b0);
        repeat (12) tick();
        check("es_pre", 32'(cur_speed), 32'd3);
        estop = 1'b1;
        tick();
        check("es_psw",   32'(psw),           32'd0);
        check("es_busy",  32'(busy),          32'd1);
        check("es_ready", 32'(bus.cmd_ready), 32'd0);
        hs_base       = n_hs;
        bus.cmd_speed = 2'b01;
        bus.cmd_dir   = 1'b0;
        bus.cmd_valid = 1'b1;
        repeat (3) tick();
        check("es_no_accept", 32'(n_hs - hs_base), 32'd0);
        check("es_speed",     32'(cur_speed),      32'd0);
        bus.cmd_valid = 1'b0;
        estop = 1'b0;
        tick();
        check("es_release_ready", 32'(bus.cmd_ready), 32'd1);
        check("es_release_busy",  32'(busy),          32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
